// File: rtl/puck_engine_param.sv
// puck_engine_param: air-hockey puck physics, paddle/wall bounces, goal
// detection, scoring and serve sequencing, advanced once per frame tick.
// Optional feature macro: PUCK_SPEEDUP_EN -- when defined, every paddle hit
// adds 1 to |vx| (capped at MAX_SPD); otherwise |vx| is always 1.
module puck_engine_param #(
   parameter int SCR_W     = 640,
   parameter int SCR_H     = 480,
   parameter int POS_W     = 11,
   parameter int SCORE_W   = 3,
   parameter int WIN_SCORE = 7,
   parameter int GOAL_TOP  = 180,
   parameter int GOAL_BOT  = 300,
   parameter int SERVE_DLY = 60,
   parameter int MAX_SPD   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               start,
   input  logic [POS_W-1:0]   Lx,
   input  logic [POS_W-1:0]   Ly,
   input  logic [POS_W-1:0]   Rx,
   input  logic [POS_W-1:0]   Ry,
   input  logic [POS_W-1:0]   Pradius,
   input  logic [POS_W-1:0]   Rradius,
   output logic [POS_W-1:0]   puckX,
   output logic [POS_W-1:0]   puckY,
   output logic [2:0]         puckstate,
   output logic [SCORE_W-1:0] GL,
   output logic [SCORE_W-1:0] GR,
   output logic               goal,
   output logic [1:0]         winner
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SERVE  = 3'd1;
   localparam logic [2:0] S_MOVE   = 3'd2;
   localparam logic [2:0] S_GOAL_L = 3'd3;
   localparam logic [2:0] S_GOAL_R = 3'd4;
   localparam logic [2:0] S_OVER   = 3'd5;

`ifdef PUCK_SPEEDUP_EN
   localparam bit SPEEDUP = 1'b1;
`else
   localparam bit SPEEDUP = 1'b0;
`endif

   localparam int DLY_W = (SERVE_DLY > 1) ? $clog2(SERVE_DLY) : 1;
   localparam int EW    = POS_W + 2;

   localparam logic [POS_W-1:0]   CTR_X    = POS_W'(SCR_W / 2);
   localparam logic [POS_W-1:0]   CTR_Y    = POS_W'(SCR_H / 2);
   localparam logic [POS_W-1:0]   X_EDGE   = POS_W'(SCR_W - 1);
   localparam logic [POS_W-1:0]   Y_EDGE   = POS_W'(SCR_H - 1);
   localparam logic [POS_W-1:0]   G_TOP    = POS_W'(GOAL_TOP);
   localparam logic [POS_W-1:0]   G_BOT    = POS_W'(GOAL_BOT);
   localparam logic [POS_W-1:0]   ONE_P    = POS_W'(1);
   localparam logic [POS_W-1:0]   SPD_CAP  = POS_W'(MAX_SPD);
   localparam logic [SCORE_W-1:0] WIN_M1   = SCORE_W'(WIN_SCORE - 1);
   localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(SERVE_DLY - 1);

   logic [2:0]         state_q, state_d;
   logic [POS_W-1:0]   x_q, x_d, y_q, y_d, spd_q, spd_d;
   logic               vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
   logic [SCORE_W-1:0] gl_q, gl_d, gr_q, gr_d;
   logic [1:0]         winner_q, winner_d;
   logic               goal_q, goal_d;
   logic [DLY_W-1:0]   dly_q, dly_d;

   logic [POS_W-1:0]   x_hi, y_hi, dxl, dyl, dxr, dyr, spd_bump;
   logic [POS_W:0]     reach;
   logic               at_left, at_right, at_top, at_bot, in_mouth, goal_hit;
   logic               hit_l, hit_r;
   logic               mv_vx_neg, mv_vy_neg;
   logic [POS_W-1:0]   mv_spd, mv_x, mv_y;
   logic signed [EW-1:0] nx_s, ny_s;
   logic               do_serve, serve_left;

   // Playfield limits, wall contacts and paddle distances (one extra bit so
   // the radius sum can never wrap).
   assign x_hi     = X_EDGE - Pradius;
   assign y_hi     = Y_EDGE - Pradius;
   assign reach    = {1'b0, Pradius} + {1'b0, Rradius};
   assign dxl      = (x_q >= Lx) ? (x_q - Lx) : (Lx - x_q);
   assign dyl      = (y_q >= Ly) ? (y_q - Ly) : (Ly - y_q);
   assign dxr      = (x_q >= Rx) ? (x_q - Rx) : (Rx - x_q);
   assign dyr      = (y_q >= Ry) ? (y_q - Ry) : (Ry - y_q);
   assign at_left  = vx_neg_q && (x_q <= Pradius);
   assign at_right = !vx_neg_q && (x_q >= x_hi);
   assign at_top   = vy_neg_q && (y_q <= Pradius);
   assign at_bot   = !vy_neg_q && (y_q >= y_hi);
   assign in_mouth = (y_q >= G_TOP) && (y_q <= G_BOT);
   assign goal_hit = (at_left || at_right) && in_mouth;
   assign hit_l    = vx_neg_q && ({1'b0, dxl} <= reach) && ({1'b0, dyl} <= reach);
   assign hit_r    = !vx_neg_q && ({1'b0, dxr} <= reach) && ({1'b0, dyr} <= reach);
   assign spd_bump = (SPEEDUP && (spd_q < SPD_CAP)) ? (spd_q + ONE_P) : spd_q;

   // Resolve bounces (paddle beats wall) and compute the clamped next position.
   always_comb begin
      mv_vx_neg = vx_neg_q;
      mv_vy_neg = vy_neg_q;
      mv_spd    = spd_q;
      if (hit_l) begin
         mv_vx_neg = 1'b0;
         mv_vy_neg = (y_q < Ly);
         mv_spd    = spd_bump;
      end else if (hit_r) begin
         mv_vx_neg = 1'b1;
         mv_vy_neg = (y_q < Ry);
         mv_spd    = spd_bump;
      end else begin
         if (at_left || at_right) mv_vx_neg = ~vx_neg_q;
         if (at_top || at_bot)    mv_vy_neg = ~vy_neg_q;
      end
      nx_s = mv_vx_neg ? ($signed({2'b00, x_q}) - $signed({2'b00, mv_spd}))
                       : ($signed({2'b00, x_q}) + $signed({2'b00, mv_spd}));
      ny_s = mv_vy_neg ? ($signed({2'b00, y_q}) - $signed({2'b00, ONE_P}))
                       : ($signed({2'b00, y_q}) + $signed({2'b00, ONE_P}));
      if (nx_s < $signed({2'b00, Pradius}))   mv_x = Pradius;
      else if (nx_s > $signed({2'b00, x_hi})) mv_x = x_hi;
      else                                    mv_x = nx_s[POS_W-1:0];
      if (ny_s < $signed({2'b00, Pradius}))   mv_y = Pradius;
      else if (ny_s > $signed({2'b00, y_hi})) mv_y = y_hi;
      else                                    mv_y = ny_s[POS_W-1:0];
   end

   // Game FSM: serve, rally, goal hold-off, scoring and game-over handling.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      vx_neg_d   = vx_neg_q;
      vy_neg_d   = vy_neg_q;
      spd_d      = spd_q;
      gl_d       = gl_q;
      gr_d       = gr_q;
      winner_d   = winner_q;
      dly_d      = dly_q;
      goal_d     = 1'b0;
      do_serve   = 1'b0;
      serve_left = 1'b1;
      case (state_q)
         S_IDLE: if (start) do_serve = 1'b1;
         S_SERVE: if (tick) state_d = S_MOVE;
         S_MOVE: if (tick) begin
            if (goal_hit) begin
               goal_d = 1'b1;
               dly_d  = '0;
               if (at_left) begin
                  gr_d = gr_q + SCORE_W'(1);
                  if (gr_q == WIN_M1) begin
                     state_d  = S_OVER;
                     winner_d = 2'b10;
                  end else begin
                     state_d = S_GOAL_R;
                  end
               end else begin
                  gl_d = gl_q + SCORE_W'(1);
                  if (gl_q == WIN_M1) begin
                     state_d  = S_OVER;
                     winner_d = 2'b01;
                  end else begin
                     state_d = S_GOAL_L;
                  end
               end
            end else begin
               x_d      = mv_x;
               y_d      = mv_y;
               vx_neg_d = mv_vx_neg;
               vy_neg_d = mv_vy_neg;
               spd_d    = mv_spd;
            end
         end
         S_GOAL_L, S_GOAL_R: if (tick) begin
            if (dly_q == DLY_LAST) begin
               do_serve   = 1'b1;
               serve_left = (state_q == S_GOAL_R);
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         S_OVER: if (tick && start) begin
            do_serve = 1'b1;
            gl_d     = '0;
            gr_d     = '0;
            winner_d = 2'b00;
         end
         default: state_d = S_IDLE;
      endcase
      if (do_serve) begin
         state_d  = S_SERVE;
         x_d      = CTR_X;
         y_d      = CTR_Y;
         vx_neg_d = serve_left;
         vy_neg_d = 1'b0;
         spd_d    = ONE_P;
         dly_d    = '0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         x_q      <= CTR_X;
         y_q      <= CTR_Y;
         vx_neg_q <= 1'b1;
         vy_neg_q <= 1'b0;
         spd_q    <= ONE_P;
         gl_q     <= '0;
         gr_q     <= '0;
         winner_q <= 2'b00;
         goal_q   <= 1'b0;
         dly_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vx_neg_q <= vx_neg_d;
         vy_neg_q <= vy_neg_d;
         spd_q    <= spd_d;
         gl_q     <= gl_d;
         gr_q     <= gr_d;
         winner_q <= winner_d;
         goal_q   <= goal_d;
         dly_q    <= dly_d;
      end
   end

   assign puckX     = x_q;
   assign puckY     = y_q;
   assign puckstate = state_q;
   assign GL        = gl_q;
   assign GR        = gr_q;
   assign goal      = goal_q;
   assign winner    = winner_q;

endmodule
